// File: rtl/truth_table_scanner.sv
// rtl/truth_table_scanner.sv - sweeps every input vector of a combinational function and captures/checks its truth table
// WAIT holds each vector for SETTLE cycles, SAMPLE captures dut_out, DONE pulses once with the verdict.
module truth_table_scanner #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2**N_IN-1:0]   expected,
  output logic [N_IN-1:0]      dut_in,
  input  logic                 dut_out,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   table_word,
  output logic                 pass,
  output logic [N_IN:0]        mismatch_cnt,
  output logic [N_IN-1:0]      mismatch_idx
);

  localparam int W  = 2**N_IN;
  localparam int CW = $clog2(SETTLE + 1);

  if (SETTLE < 1) begin : g_bad_settle
    $error("SETTLE must be at least 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SAMPLE, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [N_IN-1:0] idx;
  logic [CW-1:0]   wcnt;
  logic [W-1:0]    expected_reg;
  logic [W-1:0]    table_nxt;
  logic            last_row;
  logic            row_miss;

  assign dut_in   = idx;
  assign last_row = (idx == N_IN'(W - 1));
  assign row_miss = (dut_out != expected_reg[idx]);

  always_comb begin
    table_nxt      = table_word;
    table_nxt[idx] = dut_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_WAIT;
      S_WAIT:   if (wcnt == CW'(1)) state_nxt = S_SAMPLE;
      S_SAMPLE: state_nxt = last_row ? S_DONE : S_WAIT;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_WAIT) || (state == S_SAMPLE);
    done = (state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx          <= '0;
      wcnt         <= '0;
      expected_reg <= '0;
      table_word   <= '0;
      pass         <= 1'b0;
      mismatch_cnt <= '0;
      mismatch_idx <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            expected_reg <= expected;
            table_word   <= '0;
            pass         <= 1'b0;
            mismatch_cnt <= '0;
            mismatch_idx <= '0;
            idx          <= '0;
            wcnt         <= CW'(SETTLE);
          end
        end
        S_WAIT: wcnt <= wcnt - CW'(1);
        S_SAMPLE: begin
          table_word <= table_nxt;
          if (row_miss) begin
            mismatch_cnt <= mismatch_cnt + (N_IN+1)'(1);
            // Only the first failing row of a scan is reported
            if (mismatch_cnt == '0) mismatch_idx <= idx;
          end
          if (last_row) begin
            pass <= (table_nxt == expected_reg);
          end else begin
            idx  <= idx + N_IN'(1);
            wcnt <= CW'(SETTLE);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_scanner.sv
// tb/tb_truth_table_scanner.sv - randomized self-checking bench for truth_table_scanner
// A combinational instance (SETTLE=1) and a two-cycle-path instance (SETTLE=3) share one clock.
module tb_truth_table_scanner;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start0 = 1'b0, start1 = 1'b0;
  logic [7:0] exp0 = '0, exp1 = '0, func0 = '0, func1 = '0;
  logic [2:0] din0, din1, midx0, midx1;
  logic       dout0, dout1, dreg1;
  logic       busy0, busy1, done0, done1, pass0, pass1;
  logic [7:0] tab0, tab1;
  logic [3:0] mcnt0, mcnt1;

  int n_chk = 0;
  int n_pass = 0;

  assign dout0 = func0[din0];
  always @(posedge clk) dreg1 <= func1[din1];
  assign dout1 = dreg1;

  truth_table_scanner #(.N_IN(3), .SETTLE(1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .expected(exp0), .dut_in(din0),
    .dut_out(dout0), .busy(busy0), .done(done0), .table_word(tab0), .pass(pass0),
    .mismatch_cnt(mcnt0), .mismatch_idx(midx0));

  truth_table_scanner #(.N_IN(3), .SETTLE(3)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .expected(exp1), .dut_in(din1),
    .dut_out(dout1), .busy(busy1), .done(done1), .table_word(tab1), .pass(pass1),
    .mismatch_cnt(mcnt1), .mismatch_idx(midx1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) $display("FAIL %s: got %0h expected %0h", tag, got, want);
    else n_pass++;
  endtask

  function automatic int popcnt(input logic [7:0] v);
    int c = 0;
    for (int i = 0; i < 8; i++) c += int'(v[i]);
    return c;
  endfunction

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [31:0] outs(input int inst);
    if (inst == 0) return {din0, busy0, done0, tab0, pass0, mcnt0, midx0};
    return {din1, busy1, done1, tab1, pass1, mcnt1, midx1};
  endfunction

  // One accepted scan; expected is overwritten with e2 at edge chg_at to prove it was latched
  task automatic run_scan(input string tag, input int inst, input logic [7:0] f,
                          input logic [7:0] e, input int chg_at, input logic [7:0] e2);
    int s = (inst == 0) ? 1 : 3;
    int last = 8 * (s + 1);
    int ndone = 0, done_at = -1, busy_bad = 0, din_bad = 0;
    logic b, d;
    logic [2:0] di;
    logic [7:0] diff = f ^ e;
    @(negedge clk);
    if (inst == 0) begin func0 = f; exp0 = e; start0 = 1'b1; end
    else begin func1 = f; exp1 = e; start1 = 1'b1; end
    for (int k = 0; k <= last + 3; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin start0 = 1'b0; start1 = 1'b0; end
      if (k == chg_at) begin if (inst == 0) exp0 = e2; else exp1 = e2; end
      b  = (inst == 0) ? busy0 : busy1;
      d  = (inst == 0) ? done0 : done1;
      di = (inst == 0) ? din0 : din1;
      if (d) begin ndone++; done_at = k; end
      if ((k < last) != b) busy_bad++;
      if (di != ((k < last) ? 3'(k / (s + 1)) : 3'd7)) din_bad++;
    end
    check({tag, "_ndone"}, ndone, 1);
    check({tag, "_done_at"}, done_at, last);
    check({tag, "_busy"}, busy_bad, 0);
    check({tag, "_din"}, din_bad, 0);
    check({tag, "_table"}, (inst == 0) ? tab0 : tab1, f);
    check({tag, "_pass"}, (inst == 0) ? pass0 : pass1, f == e);
    check({tag, "_mcnt"}, (inst == 0) ? mcnt0 : mcnt1, popcnt(diff));
    check({tag, "_midx"}, (inst == 0) ? midx0 : midx1, lowest(diff));
  endtask

  initial begin
    int dq[$];
    int bad, reached, ndone;
    logic [7:0] f, e;

    #2;
    check("rst_out0", outs(0), 0);
    check("rst_out1", outs(1), 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("rst_idle_busy", busy0, 0);

    run_scan("and_or", 0, 8'hEA, 8'hEA, -1, 8'h00);
    run_scan("stuck0", 0, 8'h00, 8'h96, -1, 8'h00);

    // start held high: back-to-back scans every 18 edges
    @(negedge clk); func0 = 8'h96; exp0 = 8'h96; start0 = 1'b1;
    bad = 0;
    for (int k = 0; k <= 58; k++) begin
      @(posedge clk); #1;
      if (done0) begin
        dq.push_back(k);
        if (tab0 != 8'h96 || !pass0) bad++;
      end
      if (k == 52) start0 = 1'b0;
    end
    check("b2b_count", dq.size(), 3);
    if (dq.size() == 3) begin
      check("b2b_e16", dq[0], 16);
      check("b2b_e34", dq[1], 34);
      check("b2b_e52", dq[2], 52);
    end
    check("b2b_result", bad, 0);

    // reset mid-scan while dut_in==5
    @(negedge clk); func0 = 8'h5A; exp0 = 8'h00; start0 = 1'b1;
    @(posedge clk); #1; start0 = 1'b0;
    reached = 0;
    for (int i = 0; i < 40 && !reached; i++) begin
      if (din0 == 3'd5) reached = 1;
      else begin @(posedge clk); #1; end
    end
    check("abort_reach5", reached, 1);
    rst_n = 1'b0; #1;
    check("abort_clear", outs(0), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (30) begin @(posedge clk); #1; if (done0) ndone++; end
    check("abort_nodone", ndone, 0);
    f = 8'($urandom);
    run_scan("post_abort", 0, f, 8'h5A, -1, 8'h00);

    for (int i = 0; i < 6; i++) begin
      f = 8'($urandom);
      e = (i % 3 == 0) ? f : 8'($urandom);
      run_scan($sformatf("rnd%0d", i), 0, f, e, int'($urandom_range(2, 12)), 8'($urandom));
    end

    run_scan("slow_path", 1, 8'hEA, 8'hEA, 10, 8'h00);
    for (int i = 0; i < 2; i++) begin
      f = 8'($urandom);
      e = (i == 0) ? f : 8'($urandom);
      run_scan($sformatf("slow_rnd%0d", i), 1, f, e, int'($urandom_range(2, 25)), 8'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/truth_table_scanner.md
# truth_table_scanner

Hardware truth-table capture unit. On request it sweeps every input combination into a combinational logic function under test, waits a programmable settle time, samples the function's single output, and assembles the complete truth table as one word. It also compares that table against an expected word and reports pass/fail, the number of mismatching rows and the first failing row. It sits beside any combinational function block in the design and replaces sweep-and-print benches with a self-checking, synthesizable sweep.

## Interface
- N_IN, default 3: number of function inputs; table width is 2^N_IN.
- SETTLE, default 1: cycles each input vector is held before sampling; legal range ≥1 (0 illegal).

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  scan request; accepted only in IDLE.
- expected  in  2^N_IN  reference table; bit k = required output for input k; registered when start is accepted.
- dut_in  out  N_IN  input vector to the function; MSB = first operand (a), LSB = last (c).
- dut_out  in  1  function output; combinational response to dut_in.
- busy  out  1  high from the cycle after start is accepted through the last SAMPLE cycle.
- done  out  1  one-cycle pulse when the scan completes.
- table  out  2^N_IN  captured table; bit k = dut_out sampled while dut_in == k.
- pass  out  1  table == expected; valid from done, held.
- mismatch_cnt  out  N_IN+1  number of rows where table differs from expected.
- mismatch_idx  out  N_IN  lowest failing row index; 0 when none.

## Operation
- States: IDLE, WAIT, SAMPLE, DONE.
- IDLE, start=1 at an edge:
  - latch expected;
  - clear table, pass, mismatch_cnt and mismatch_idx;
  - set idx=0, dut_in=0, wcnt=SETTLE;
  - go to WAIT.
- WAIT: decrement wcnt each edge; go to SAMPLE at the edge where wcnt==1. WAIT lasts exactly SETTLE cycles.
- SAMPLE, at its closing edge:
  - table[idx] <= dut_out.
  - If dut_out != expected_reg[idx], increment mismatch_cnt. Also set mismatch_idx=idx if this is the first mismatch of the scan.
  - If idx == 2^N_IN−1, go to DONE.
  - Otherwise idx++, dut_in <= idx+1, wcnt <= SETTLE, and go to WAIT.
- DONE: done=1 and pass=(table==expected_reg) for exactly one cycle, then go to IDLE. pass stays registered after DONE.
- start is ignored in WAIT, SAMPLE and DONE; it is not queued.
- Changes to expected after acceptance have no effect on the scan in progress.
- table, pass, mismatch_cnt and mismatch_idx hold their values until the next accepted start.
- dut_in holds its last vector (all ones) after the scan completes.
- Reset (any time, including mid-scan):
  - all outputs go to 0 immediately;
  - state goes to IDLE;
  - idx and wcnt are cleared;
  - no done is issued for the aborted scan.

## Timing
- Let E0 be the edge at which start is accepted.
- Vector k is driven from E0 + k·(SETTLE+1) and sampled at edge E0 + (k+1)·(SETTLE+1).
- done is high between edges E0 + 2^N_IN·(SETTLE+1) and the next edge.
  - Defaults: done is high between E16 and E17.
- busy rises after E0 and falls at the edge where done rises.
- With start held high, back-to-back scans are accepted every 2^N_IN·(SETTLE+1)+2 edges (one DONE cycle plus one IDLE cycle). Defaults: every 18 edges.
- Reset values: dut_in=0, busy=0, done=0, table=0, pass=0, mismatch_cnt=0, mismatch_idx=0.

## Test plan
1. Reset: assert rst_n=0 mid-clock with no clock edge → all outputs read 0 immediately. Release → IDLE, busy=0.
2. Defaults, dut_out=(a&b)|c from dut_in, expected=8'hEA, one-cycle start pulse → busy high after E0, single done pulse after E16, table=8'hEA, pass=1, mismatch_cnt=0, mismatch_idx=0.
3. Defaults, bench holds dut_out=0, expected=8'h96 (a^b^c) → table=8'h00, pass=0, mismatch_cnt=4, mismatch_idx=1.
4. start held high for three scans, function a^b^c, expected=8'h96 → done pulses at E16, E34 and E52. Each pulse shows table=8'h96 and pass=1. start during busy has no visible effect.
5. rst_n pulsed low while dut_in=5, then start pulse → all outputs clear on the reset. No done for the aborted scan. The new scan completes normally with a full table and no stale bits.
6. SETTLE=3, dut_out=(a&b)|c registered one cycle late (2-cycle path), expected=8'hEA, expected changed to 8'h00 at E10 → done after E32, table=8'hEA, pass=1.
